// File: rtl/booth4_seq_mult_if.sv
// Operand/product handshake bundle for the sequential radix-4 Booth multiplier.
// The master drives operands and accepts products; the slave is the multiplier.
interface booth4_seq_mult_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one recoded digit per cycle, signed WIDTH x WIDTH
// operands, 2*WIDTH-bit product, valid/ready on both sides.
module booth4_seq_mult #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  booth4_seq_mult_if.slave   bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [MW-1:0]     mplr_q, mplr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [2:0]        trip;
  logic              pp_one;
  logic              pp_two;
  logic              pp_neg;
  logic [PW-1:0]     pp_mag;
  logic [PW-1:0]     pp_inv;
  logic [PW-1:0]     pp_sum;

  // Booth decode of the current triplet; negation is invert-plus-carry-in.
  always_comb begin
    trip   = mplr_q[2:0];
    pp_one = (trip == 3'b001) || (trip == 3'b010) || (trip == 3'b101) || (trip == 3'b110);
    pp_two = (trip == 3'b011) || (trip == 3'b100);
    pp_neg = trip[2] && (trip != 3'b111);
    pp_mag = '0;
    if (pp_two) begin
      pp_mag = mcand_q << 1;
    end else if (pp_one) begin
      pp_mag = mcand_q;
    end
    pp_inv = pp_mag ^ {PW{pp_neg}};
    pp_sum = acc_q + pp_inv + PW'(pp_neg);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mcand_d = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
          mplr_d  = {bus.b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = pp_sum;
        mcand_d = mcand_q << 2;
        mplr_d  = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH / 2 - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes the sum; later cycles hold it until accepted.
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (!out_valid_q) begin
          out_valid_d = 1'b1;
          product_d   = acc_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Directed and random checks of booth4_seq_mult against a behavioural a*b model,
// with expected products queued at accept and consumed at the output handshake.
module tb_booth4_seq_mult;

  logic clk;
  logic rst_n;

  booth4_seq_mult_if #(.WIDTH(16)) bus ();

  booth4_seq_mult #(.WIDTH(16), .CNT_W(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_fail;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, count latency, optional stall, handshake.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall,
                       input bit noise);
    bit          seen;
    int          lat;
    logic [31:0] exp;

    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.in_ready) seen = 1'b1;
      else tick();
    end
    check("in_ready_wait", 32'(seen), 32'd1);

    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp = 32'($signed(a)) * 32'($signed(b));
    sb.push_back(exp);

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
      end
      tick();
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    check("out_valid_seen", 32'(seen), 32'd1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    check("latency", 32'(lat), 32'd9);

    if (stall > 0) begin
      bus.out_ready = 1'b0;
      if (noise) begin
        bus.in_valid = 1'b1;
        bus.a = 16'd9;
        bus.b = 16'd9;
      end
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_product", bus.product, exp);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end

    check("product", bus.product, sb.pop_front());
    tick();
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("product_hold", bus.product, exp);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", bus.product, 32'd0);

    // Reset in the 4th CALC cycle aborts the operation.
    bus.a = 16'd11;
    bus.b = 16'd13;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_in_ready_post", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid_post", 32'(bus.out_valid), 32'd0);
    check("abort_product", bus.product, 32'd0);
    do_op(16'd3, 16'd5, 0, 1'b0);

    do_op(16'd3, 16'd5, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 0, 1'b0);
    check("min_x_min", bus.product, 32'h4000_0000);
    do_op(16'h8000, 16'h7FFF, 0, 1'b0);
    check("min_x_max", bus.product, 32'hC000_8000);
    do_op(-16'sd7, 16'sd6, 0, 1'b0);
    check("neg7_x_6", bus.product, 32'hFFFF_FFD6);
    do_op(16'h7FFF, 16'h7FFF, 0, 1'b0);
    check("max_x_max", bus.product, 32'h3FFF_0001);
    do_op(16'd1234, 16'hFFFF, 0, 1'b0);
    check("1234_x_neg1", bus.product, 32'hFFFF_FB2E);

    // Stall in DONE with a competing operand pair that must be ignored.
    do_op(16'd100, -16'sd3, 5, 1'b1);
    check("stall_result", bus.product, 32'hFFFF_FED4);
    repeat (2) begin
      tick();
      check("no_spurious_valid", 32'(bus.out_valid), 32'd0);
    end
    do_op(16'd2, 16'd2, 0, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
